// File: rtl/npu_ctrl_pkg.sv
// Shared types and constants for the NPU convolution window sequencer.
package npu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MAC,
        DRAIN,
        DONE
    } seq_state_t;

    localparam int K_SIZE_DEF    = 3;
    localparam int TAPS          = K_SIZE_DEF * K_SIZE_DEF;
    localparam int X_BCAST_BASE  = 0;
    localparam int X_DIRECT_BASE = TAPS;

    localparam logic MODE_MAC = 1'b0;
    localparam logic MODE_ALT = 1'b1;

endpackage

// File: rtl/npu_seq_counter.sv
// Loadable down-counter; expired_o flags terminal count (zero).
module npu_seq_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/npu_conv_sequencer.sv
// Steps one K_SIZE x K_SIZE convolution window across the PE array.
// IDLE: wait for start | CLEAR: clear accumulators | MAC: one tap per cycle
// DRAIN: let the PE pipeline empty | DONE: one-cycle completion pulse
module npu_conv_sequencer
    import npu_ctrl_pkg::*;
#(
    parameter int N       = 10,
    parameter int K_SIZE  = K_SIZE_DEF,
    parameter int PE_LAT  = 2,
    parameter int W_SEL_W = $clog2(K_SIZE * K_SIZE),
    parameter int X_SEL_W = $clog2(2 * K_SIZE * K_SIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [N-1:0]       pe_mask_i,
    input  logic               bcast_i,
    input  logic               clear_i,
    input  logic               mode_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [N-1:0]       pe_en_o,
    output logic [N-1:0]       pe_mode_sel_o,
    output logic [N-1:0]       pe_reg_reset_o,
    output logic [W_SEL_W-1:0] w_sel_o,
    output logic [X_SEL_W-1:0] x_sel_o,
    output logic [W_SEL_W-1:0] tap_o
);

    localparam int TAPS_L = K_SIZE * K_SIZE;
    localparam int DRN_W  = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [W_SEL_W-1:0] TAP_LAST = W_SEL_W'(TAPS_L - 1);
    localparam logic [DRN_W-1:0]   DRN_LAST = DRN_W'(PE_LAT - 1);

    seq_state_t state_q, state_d;
    logic [N-1:0] mask_q, mask_d;
    logic         bcast_q, bcast_d;
    logic         mode_q, mode_d;

    logic tap_load, tap_dec, tap_expired;
    logic drn_load, drn_dec, drn_expired;
    logic cnt_clr;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [N-1:0]       pe_en_q, pe_en_d;
    logic [N-1:0]       mode_sel_q, mode_sel_d;
    logic [N-1:0]       reg_reset_q, reg_reset_d;
    logic [W_SEL_W-1:0] tap_q, tap_d;
    logic [X_SEL_W-1:0] x_sel_q, x_sel_d;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        bcast_d  = bcast_q;
        mode_d   = mode_q;
        tap_load = 1'b0;
        tap_dec  = 1'b0;
        drn_load = 1'b0;
        drn_dec  = 1'b0;
        cnt_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    mask_d  = pe_mask_i;
                    bcast_d = bcast_i;
                    mode_d  = mode_i;
                    if (clear_i) begin
                        state_d = CLEAR;
                    end else begin
                        state_d  = MAC;
                        tap_load = 1'b1;
                    end
                end
            end
            CLEAR: begin
                state_d  = MAC;
                tap_load = 1'b1;
            end
            MAC: begin
                if (tap_expired) begin
                    state_d  = DRAIN;
                    drn_load = 1'b1;
                end else begin
                    tap_dec = 1'b1;
                end
            end
            DRAIN: begin
                if (drn_expired) begin
                    state_d = DONE;
                end else begin
                    drn_dec = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over every transition, including the counter updates.
        if ((state_q != IDLE) && abort_i) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge.
    always_comb begin
        busy_d      = (state_d inside {CLEAR, MAC, DRAIN});
        done_d      = (state_d == DONE);
        pe_en_d     = (state_d == MAC) ? mask_d : '0;
        reg_reset_d = (state_d == CLEAR) ? mask_d : '0;
        mode_sel_d  = busy_d ? ({N{mode_d}} & mask_d) : '0;
        tap_d       = '0;
        x_sel_d     = '0;
        if (state_d == MAC) begin
            tap_d = (state_q == MAC) ? tap_q + W_SEL_W'(1) : '0;
        end else if (state_d == DRAIN) begin
            tap_d = tap_q;
        end
        if (state_d inside {MAC, DRAIN}) begin
            x_sel_d = bcast_d ? X_SEL_W'(X_BCAST_BASE) + X_SEL_W'(tap_d)
                              : X_SEL_W'(TAPS_L) + X_SEL_W'(tap_d);
        end
    end

    npu_seq_counter #(.W(W_SEL_W)) u_tap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cnt_clr),
        .load_i     (tap_load),
        .load_val_i (TAP_LAST),
        .dec_i      (tap_dec),
        .expired_o  (tap_expired)
    );

    npu_seq_counter #(.W(DRN_W)) u_drn_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cnt_clr),
        .load_i     (drn_load),
        .load_val_i (DRN_LAST),
        .dec_i      (drn_dec),
        .expired_o  (drn_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            bcast_q     <= 1'b0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pe_en_q     <= '0;
            mode_sel_q  <= '0;
            reg_reset_q <= '0;
            tap_q       <= '0;
            x_sel_q     <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            bcast_q     <= bcast_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pe_en_q     <= pe_en_d;
            mode_sel_q  <= mode_sel_d;
            reg_reset_q <= reg_reset_d;
            tap_q       <= tap_d;
            x_sel_q     <= x_sel_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pe_en_o        = pe_en_q;
    assign pe_mode_sel_o  = mode_sel_q;
    assign pe_reg_reset_o = reg_reset_q;
    assign w_sel_o        = tap_q;
    assign tap_o          = tap_q;
    assign x_sel_o        = x_sel_q;

endmodule

// File: tb/tb_npu_conv_sequencer.sv
// Bench for npu_conv_sequencer: directed scenarios plus random traffic against a run/offset model.
module tb_npu_conv_sequencer;

    localparam int N      = 10;
    localparam int TAPS   = 9;
    localparam int PE_LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i, bcast_i, clear_i, mode_i, abort_i;
    logic [N-1:0] pe_mask_i;
    logic         busy_o, done_o;
    logic [N-1:0] pe_en_o, pe_mode_sel_o, pe_reg_reset_o;
    logic [3:0]   w_sel_o, tap_o;
    logic [4:0]   x_sel_o;

    int checks = 0;
    int errors = 0;

    // Model: a run is "active" with offset m_k = cycles since the accepting edge.
    bit           m_act = 1'b0;
    int           m_k = 0;
    logic [N-1:0] m_mask = '0;
    bit           m_bcast = 1'b0, m_clear = 1'b0, m_mode = 1'b0;

    always #5 clk = ~clk;

    npu_conv_sequencer #(.N(N), .K_SIZE(3), .PE_LAT(PE_LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .pe_mask_i      (pe_mask_i),
        .bcast_i        (bcast_i),
        .clear_i        (clear_i),
        .mode_i         (mode_i),
        .abort_i        (abort_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .pe_en_o        (pe_en_o),
        .pe_mode_sel_o  (pe_mode_sel_o),
        .pe_reg_reset_o (pe_reg_reset_o),
        .w_sel_o        (w_sel_o),
        .x_sel_o        (x_sel_o),
        .tap_o          (tap_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int run_len(input bit clr);
        return int'(clr) + TAPS + PE_LAT + 1;
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_act = 1'b0;
        end else if (m_act) begin
            if (abort_i || m_k == run_len(m_clear)) m_act = 1'b0;
            else m_k++;
        end else if (start_i && !abort_i) begin
            m_act   = 1'b1;
            m_k     = 1;
            m_mask  = pe_mask_i;
            m_bcast = bcast_i;
            m_clear = clear_i;
            m_mode  = mode_i;
        end
    endtask

    task automatic check_all();
        logic [N-1:0] e_en, e_rr, e_ms;
        logic [31:0]  e_w, e_x;
        logic         e_busy, e_done;
        int c, t;
        e_en = '0; e_rr = '0; e_ms = '0; e_w = 0; e_x = 0; e_busy = 0; e_done = 0;
        if (m_act) begin
            c = int'(m_clear);
            if (m_k <= c) begin
                e_rr = m_mask; e_busy = 1;
            end else if (m_k <= c + TAPS) begin
                t = m_k - c - 1;
                e_en = m_mask; e_busy = 1;
                e_w = t; e_x = m_bcast ? t : TAPS + t;
            end else if (m_k <= c + TAPS + PE_LAT) begin
                t = TAPS - 1;
                e_busy = 1;
                e_w = t; e_x = m_bcast ? t : TAPS + t;
            end else begin
                e_done = 1;
            end
            if (e_busy && m_mode) e_ms = m_mask;
        end
        chk("busy", busy_o, e_busy);
        chk("done", done_o, e_done);
        chk("pe_en", pe_en_o, e_en);
        chk("pe_reg_reset", pe_reg_reset_o, e_rr);
        chk("pe_mode_sel", pe_mode_sel_o, e_ms);
        chk("w_sel", w_sel_o, e_w);
        chk("tap", tap_o, e_w);
        chk("x_sel", x_sel_o, e_x);
    endtask

    task automatic cyc(input logic s, input logic a);
        start_i = s;
        abort_i = a;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Start one run, scramble inputs afterwards, and measure done cycle and busy length.
    task automatic run_directed(input logic [N-1:0] mask, input logic clr, input logic bc,
                                input logic md, input int exp_done, input string tag);
        int first_done, busy_cnt;
        first_done = -1;
        busy_cnt   = 0;
        pe_mask_i = mask; clear_i = clr; bcast_i = bc; mode_i = md;
        for (int n = 1; n <= 20; n++) begin
            cyc(n == 1, 1'b0);
            pe_mask_i = N'($urandom); clear_i = 1'($urandom); bcast_i = 1'($urandom);
            mode_i = 1'($urandom);
            if (done_o === 1'b1 && first_done < 0) first_done = n;
            if (busy_o === 1'b1) busy_cnt++;
        end
        chk({tag, "_done_cycle"}, first_done, exp_done);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_done - 1);
    endtask

    initial begin
        int dones, second_done;
        rst_n = 1'b0;
        start_i = 0; abort_i = 0; bcast_i = 0; clear_i = 0; mode_i = 0; pe_mask_i = '0;
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);

        run_directed(10'h3FF, 1'b1, 1'b0, 1'b1, 13, "full_clear");
        run_directed(10'h005, 1'b0, 1'b1, 1'b0, 12, "bcast_noclear");
        run_directed(10'h000, 1'b1, 1'b0, 1'b1, 13, "mask0");

        // start held through a run plus two cycles
        pe_mask_i = 10'h0F0; clear_i = 0; bcast_i = 0; mode_i = 1;
        dones = 0; second_done = -1;
        for (int n = 1; n <= 30; n++) begin
            cyc(n <= 14, 1'b0);
            if (done_o === 1'b1) begin
                dones++;
                if (dones == 2) second_done = n;
            end
        end
        chk("held_start_dones", dones, 2);
        chk("held_start_second_done", second_done, 25);

        // abort at tap 4
        pe_mask_i = 10'h2A5; clear_i = 0; bcast_i = 1; mode_i = 1;
        cyc(1'b1, 1'b0);
        for (int n = 2; n <= 5; n++) cyc(1'b0, 1'b0);
        chk("abort_tap_before", tap_o, 4);
        cyc(1'b1, 1'b1);
        chk("abort_busy_after", busy_o, 0);
        dones = 0;
        for (int n = 0; n < 15; n++) begin
            cyc(1'b0, 1'b0);
            if (done_o === 1'b1) dones++;
        end
        chk("abort_no_done", dones, 0);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        chk("idle_abort_start_ignored", busy_o, 0);
        run_directed(10'h1C3, 1'b1, 1'b1, 1'b0, 13, "after_abort");

        // async reset during DRAIN
        pe_mask_i = 10'h3FF; clear_i = 0; bcast_i = 0; mode_i = 1;
        cyc(1'b1, 1'b0);
        for (int n = 2; n <= 10; n++) cyc(1'b0, 1'b0);
        chk("drain_before_reset_busy", busy_o, 1);
        #2 rst_n = 1'b0;
        m_act = 1'b0;
        #1 check_all();
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 6; n++) begin
            cyc(1'b0, 1'b0);
            if (done_o === 1'b1) dones++;
        end
        chk("reset_no_done", dones, 0);

        // random traffic
        for (int n = 0; n < 700; n++) begin
            pe_mask_i = N'($urandom);
            clear_i   = 1'($urandom);
            bcast_i   = 1'($urandom);
            mode_i    = 1'($urandom);
            cyc(($urandom % 4) == 0, ($urandom % 40) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
